// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared types, opcodes and instruction field helpers for the ALU issue stage
// Purpose : state encoding, opcode constants and instruction field positions
//           used by the issue stage, its register file and its bus interface.
// Ports   : none (package).
package alu_issue_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_LDI = 3'b111;

   localparam int INSTR_W = 16;
   localparam int DATA_W  = 16;
   localparam int RES_W   = 32;

   // Instruction field positions; LDI reuses the rs1/rs2 area as a 10-bit immediate.
   localparam int OP_HI  = 15;
   localparam int OP_LO  = 13;
   localparam int RD_HI  = 12;
   localparam int RD_LO  = 10;
   localparam int RS1_HI = 9;
   localparam int RS1_LO = 7;
   localparam int RS2_HI = 6;
   localparam int RS2_LO = 4;
   localparam int IMM_HI = 9;
   localparam int IMM_LO = 0;

   function automatic logic is_illegal(input logic [2:0] op);
      return (op == 3'b101) || (op == 3'b110);
   endfunction

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - instruction, ALU and result bus of the ALU issue stage
// Purpose : bundles the instruction handshake, ALU operand/result wires and
//           result handshake. The stage uses the slave modport, the
//           environment (instruction source, ALU, result sink) the master one.
// Signals : instr_valid/instr/instr_ready, alu_a/alu_b/alu_opcode/alu_out,
//           res_valid/res_ready/res_data/res_rd, illegal_instr.
interface alu_issue_if;
   import alu_issue_pkg::*;

   logic                 instr_valid;
   logic [INSTR_W-1:0]   instr;
   logic                 instr_ready;
   logic [DATA_W-1:0]    alu_a;
   logic [DATA_W-1:0]    alu_b;
   logic [2:0]           alu_opcode;
   logic [RES_W-1:0]     alu_out;
   logic                 res_valid;
   logic                 res_ready;
   logic [RES_W-1:0]     res_data;
   logic [2:0]           res_rd;
   logic                 illegal_instr;

   modport slave (
      input  instr_valid, instr, alu_out, res_ready,
      output instr_ready, alu_a, alu_b, alu_opcode,
             res_valid, res_data, res_rd, illegal_instr
   );

   modport master (
      output instr_valid, instr, alu_out, res_ready,
      input  instr_ready, alu_a, alu_b, alu_opcode,
             res_valid, res_data, res_rd, illegal_instr
   );

endinterface

// File: rtl/alu_issue_regfile.sv
// rtl/alu_issue_regfile.sv - NREGS x 16 register file with two read ports, a debug port and one write port
// Purpose : architectural registers of the issue stage.
// Ports   : clk, rst_n (async active-low, entries reset to RESET_VAL),
//           ra1/rd1, ra2/rd2 (combinational operand reads),
//           dbg_addr/dbg_data (combinational debug read),
//           we/wa/wd (synchronous write).
module alu_issue_regfile #(
   parameter int          NREGS     = 8,
   parameter logic [15:0] RESET_VAL = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  ra1,
   output logic [15:0] rd1,
   input  logic [2:0]  ra2,
   output logic [15:0] rd2,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data,
   input  logic        we,
   input  logic [2:0]  wa,
   input  logic [15:0] wd
);
   logic [15:0] regs [NREGS];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= RESET_VAL;
         end
      end else if (we) begin
         regs[wa] <= wd;
      end
   end

   assign rd1      = regs[ra1];
   assign rd2      = regs[ra2];
   assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - decode / operand fetch / writeback sequencer in front of a 16x16->32 ALU
// Purpose : accepts one instruction at a time, fetches operands, drives the
//           ALU for one cycle, writes the low half of the result back and
//           holds the full result until downstream takes it. LDI skips EXEC.
// Ports   : clk, rst_n (async active-low), bus (alu_issue_if.slave),
//           dbg_addr/dbg_data (register file debug read),
//           flag_z/flag_n only when ALU_ISSUE_FLAGS_EN is defined.
module alu_issue_stage #(
   parameter int          NREGS     = 8,
   parameter logic [15:0] RESET_VAL = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_issue_if.slave  bus,
   input  logic [2:0]  dbg_addr,
   output logic [15:0] dbg_data
`ifdef ALU_ISSUE_FLAGS_EN
   ,
   output logic        flag_z,
   output logic        flag_n
`endif
);
   import alu_issue_pkg::*;

   state_t      state, state_nxt;
   logic [2:0]  in_op, in_rd, in_rs1, in_rs2;
   logic [9:0]  in_imm;
   logic        take;
   logic [2:0]  rd_q;
   logic [15:0] rs1_val, rs2_val;
   logic        we;
   logic [2:0]  wa;
   logic [15:0] wd;

   assign in_op  = bus.instr[OP_HI:OP_LO];
   assign in_rd  = bus.instr[RD_HI:RD_LO];
   assign in_rs1 = bus.instr[RS1_HI:RS1_LO];
   assign in_rs2 = bus.instr[RS2_HI:RS2_LO];
   assign in_imm = bus.instr[IMM_HI:IMM_LO];
   assign take   = (state == IDLE) && bus.instr_valid;

   alu_issue_regfile #(
      .NREGS     (NREGS),
      .RESET_VAL (RESET_VAL)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .ra1      (in_rs1),
      .rd1      (rs1_val),
      .ra2      (in_rs2),
      .rd2      (rs2_val),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data),
      .we       (we),
      .wa       (wa),
      .wd       (wd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt       = state;
      bus.instr_ready = 1'b0;
      bus.res_valid   = 1'b0;
      case (state)
         IDLE: begin
            bus.instr_ready = 1'b1;
            if (bus.instr_valid) begin
               if (in_op == OP_LDI)        state_nxt = HOLD;
               else if (!is_illegal(in_op)) state_nxt = EXEC;
            end
         end
         EXEC: state_nxt = HOLD;
         HOLD: begin
            bus.res_valid = 1'b1;
            if (bus.res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Single write port shared by LDI (at accept) and ALU writeback (end of
   // EXEC); the two can never coincide because they occur in different states.
   always_comb begin
      we = 1'b0;
      wa = rd_q;
      wd = bus.alu_out[15:0];
      if (take && (in_op == OP_LDI)) begin
         we = 1'b1;
         wa = in_rd;
         wd = {6'b0, in_imm};
      end else if (state == EXEC) begin
         we = 1'b1;
      end
   end

   // Operands are captured at the accept edge so the ALU sees constant inputs
   // for the whole EXEC cycle; the register file cannot change in between.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q              <= 3'd0;
         bus.alu_a         <= 16'd0;
         bus.alu_b         <= 16'd0;
         bus.alu_opcode    <= 3'd0;
         bus.res_data      <= 32'd0;
         bus.res_rd        <= 3'd0;
         bus.illegal_instr <= 1'b0;
      end else begin
         bus.illegal_instr <= take && is_illegal(in_op);
         if (take) begin
            rd_q <= in_rd;
            if (in_op == OP_LDI) begin
               bus.res_data <= {22'd0, in_imm};
               bus.res_rd   <= in_rd;
            end else if (!is_illegal(in_op)) begin
               bus.alu_a      <= rs1_val;
               bus.alu_b      <= rs2_val;
               bus.alu_opcode <= in_op;
            end
         end
         if (state == EXEC) begin
            bus.res_data <= bus.alu_out;
            bus.res_rd   <= rd_q;
         end
      end
   end

`ifdef ALU_ISSUE_FLAGS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
      end else if (we) begin
         flag_z <= (wd == 16'd0);
         flag_n <= wd[15];
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage with a behavioural ALU and register model
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  dbg_addr = 3'd0;
   logic [15:0] dbg_data;
`ifdef ALU_ISSUE_FLAGS_EN
   logic        flag_z, flag_n;
`endif

   alu_issue_if bus ();

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [15:0] model [8];
   logic        exp_z = 1'b0;
   logic        exp_n = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      logic [31:0] za, zb;
      za = {16'd0, a};
      zb = {16'd0, b};
      case (op)
         3'd0:    return za + zb;
         3'd1:    return za - zb;
         3'd2:    return za & zb;
         3'd3:    return za | zb;
         3'd4:    return za ^ zb;
         default: return 32'hDEADBEEF;
      endcase
   endfunction

   always_comb bus.alu_out = alu_fn(bus.alu_opcode, bus.alu_a, bus.alu_b);

   alu_issue_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .dbg_addr (dbg_addr),
      .dbg_data (dbg_data)
`ifdef ALU_ISSUE_FLAGS_EN
      ,
      .flag_z   (flag_z),
      .flag_n   (flag_n)
`endif
   );

   // Architectural effect of one instruction: kind 0 = ALU, 1 = LDI, 2 = illegal.
   task automatic model_step(input logic [15:0] ins, output logic [31:0] res, output int kind);
      logic [2:0] op, rd;
      op  = ins[15:13];
      rd  = ins[12:10];
      res = 32'd0;
      if (op == 3'b101 || op == 3'b110) begin
         kind = 2;
      end else begin
         if (op == 3'b111) begin
            kind = 1;
            res  = {22'd0, ins[9:0]};
         end else begin
            kind = 0;
            res  = alu_fn(op, model[ins[9:7]], model[ins[6:4]]);
         end
         model[rd] = res[15:0];
         exp_z     = (res[15:0] == 16'd0);
         exp_n     = res[15];
      end
   endtask

   task automatic send(input logic [15:0] ins, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.instr_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) begin
         bus.instr       = ins;
         bus.instr_valid = 1'b1;
         @(posedge clk);
         #1 bus.instr_valid = 1'b0;
      end
   endtask

   task automatic wait_result(output int lat);
      lat = 99;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (bus.res_valid === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic peek(input logic [2:0] a, output logic [15:0] v);
      dbg_addr = a;
      #1 v = dbg_data;
   endtask

   task automatic test_reset;
      logic [15:0] v;
      bus.instr_valid = 1'b0;
      bus.instr       = 16'd0;
      bus.res_ready   = 1'b1;
      rst_n           = 1'b0;
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      exp_z = 1'b0;
      exp_n = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++;
      if (bus.instr_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.illegal_instr !== 1'b0)
         $display("FAIL reset_handshake ready=%b valid=%b illegal=%b required 1/0/0",
                  bus.instr_ready, bus.res_valid, bus.illegal_instr);
      else pass_cnt++;
      total_cnt++;
      if (bus.res_data !== 32'd0 || bus.res_rd !== 3'd0 || bus.alu_a !== 16'd0 ||
          bus.alu_b !== 16'd0 || bus.alu_opcode !== 3'd0)
         $display("FAIL reset_data res_data=%h res_rd=%0d a=%h b=%h opc=%0d required all zero",
                  bus.res_data, bus.res_rd, bus.alu_a, bus.alu_b, bus.alu_opcode);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), v);
         total_cnt++;
         if (v !== 16'h0000) $display("FAIL reset_reg r%0d got %h required 0000", i, v);
         else pass_cnt++;
      end
`ifdef ALU_ISSUE_FLAGS_EN
      total_cnt++;
      if (flag_z !== 1'b0 || flag_n !== 1'b0)
         $display("FAIL reset_flags z=%b n=%b required 0/0", flag_z, flag_n);
      else pass_cnt++;
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_ldi_add;
      logic [31:0] er;
      int          kind, lat;
      bit          ok;
      logic [15:0] v;
      // LDI r1,#0x3FF
      model_step({3'b111, 3'd1, 10'h3FF}, er, kind);
      send({3'b111, 3'd1, 10'h3FF}, ok);
      wait_result(lat);
      total_cnt++;
      if (!ok || lat != 1 || bus.res_data !== 32'h0000_03FF || bus.res_rd !== 3'd1)
         $display("FAIL ldi_r1 ok=%0d lat=%0d data=%h rd=%0d required 1/1/000003ff/1",
                  ok, lat, bus.res_data, bus.res_rd);
      else pass_cnt++;
      @(posedge clk); #1;
      // LDI r2,#5
      model_step({3'b111, 3'd2, 10'd5}, er, kind);
      send({3'b111, 3'd2, 10'd5}, ok);
      wait_result(lat);
      total_cnt++;
      if (!ok || lat != 1 || bus.res_data !== 32'h0000_0005 || bus.res_rd !== 3'd2)
         $display("FAIL ldi_r2 ok=%0d lat=%0d data=%h rd=%0d required 1/1/00000005/2",
                  ok, lat, bus.res_data, bus.res_rd);
      else pass_cnt++;
      @(posedge clk); #1;
      // ADD r3,r1,r2
      model_step({3'b000, 3'd3, 3'd1, 3'd2, 4'd0}, er, kind);
      send({3'b000, 3'd3, 3'd1, 3'd2, 4'd0}, ok);
      @(negedge clk);
      total_cnt++;
      if (!ok || bus.alu_a !== 16'h03FF || bus.alu_b !== 16'h0005 || bus.alu_opcode !== 3'd0 ||
          bus.res_valid !== 1'b0 || bus.instr_ready !== 1'b0)
         $display("FAIL add_exec a=%h b=%h opc=%0d valid=%b ready=%b required 03ff/0005/0/0/0",
                  bus.alu_a, bus.alu_b, bus.alu_opcode, bus.res_valid, bus.instr_ready);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h0000_0404 || bus.res_rd !== 3'd3)
         $display("FAIL add_result valid=%b data=%h rd=%0d required 1/00000404/3",
                  bus.res_valid, bus.res_data, bus.res_rd);
      else pass_cnt++;
      peek(3'd3, v);
      total_cnt++;
      if (v !== 16'h0404) $display("FAIL add_dbg_r3 got %h required 0404", v);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_sub;
      logic [31:0] er;
      int          kind, lat;
      bit          ok;
      logic [15:0] v;
      model_step({3'b001, 3'd4, 3'd2, 3'd1, 4'd0}, er, kind);
      send({3'b001, 3'd4, 3'd2, 3'd1, 4'd0}, ok);
      wait_result(lat);
      total_cnt++;
      if (!ok || lat != 2 || bus.res_data !== 32'hFFFF_FC06 || bus.res_rd !== 3'd4)
         $display("FAIL sub_result ok=%0d lat=%0d data=%h rd=%0d required 1/2/fffffc06/4",
                  ok, lat, bus.res_data, bus.res_rd);
      else pass_cnt++;
      peek(3'd4, v);
      total_cnt++;
      if (v !== 16'hFC06) $display("FAIL sub_dbg_r4 got %h required fc06", v);
      else pass_cnt++;
`ifdef ALU_ISSUE_FLAGS_EN
      total_cnt++;
      if (flag_n !== 1'b1 || flag_z !== 1'b0)
         $display("FAIL sub_flags z=%b n=%b required 0/1", flag_z, flag_n);
      else pass_cnt++;
`endif
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      logic [31:0] er;
      int          kind, lat;
      bit          ok;
      bus.res_ready = 1'b0;
      model_step({3'b100, 3'd5, 3'd1, 3'd1, 4'd0}, er, kind);
      send({3'b100, 3'd5, 3'd1, 3'd1, 4'd0}, ok);
      wait_result(lat);
      total_cnt++;
      if (!ok || lat != 2 || bus.res_data !== 32'd0 || bus.res_rd !== 3'd5)
         $display("FAIL xor_result ok=%0d lat=%0d data=%h rd=%0d required 1/2/00000000/5",
                  ok, lat, bus.res_data, bus.res_rd);
      else pass_cnt++;
`ifdef ALU_ISSUE_FLAGS_EN
      total_cnt++;
      if (flag_z !== 1'b1 || flag_n !== 1'b0)
         $display("FAIL xor_flags z=%b n=%b required 1/0", flag_z, flag_n);
      else pass_cnt++;
`endif
      // A waiting instruction must not be taken while the result is held.
      bus.instr       = {3'b111, 3'd6, 10'h02A};
      bus.instr_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         total_cnt++;
         if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd0 || bus.res_rd !== 3'd5 ||
             bus.instr_ready !== 1'b0)
            $display("FAIL hold_cycle%0d valid=%b data=%h rd=%0d ready=%b required 1/00000000/5/0",
                     i, bus.res_valid, bus.res_data, bus.res_rd, bus.instr_ready);
         else pass_cnt++;
      end
      bus.res_ready = 1'b1;
      @(posedge clk); #1;
      total_cnt++;
      if (bus.instr_ready !== 1'b1 || bus.res_valid !== 1'b0)
         $display("FAIL hold_release ready=%b valid=%b required 1/0", bus.instr_ready, bus.res_valid);
      else pass_cnt++;
      model_step({3'b111, 3'd6, 10'h02A}, er, kind);
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      total_cnt++;
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'h0000_002A || bus.res_rd !== 3'd6)
         $display("FAIL after_release valid=%b data=%h rd=%0d required 1/0000002a/6",
                  bus.res_valid, bus.res_data, bus.res_rd);
      else pass_cnt++;
      @(posedge clk); #1;
   endtask

   task automatic test_illegal;
      logic [15:0] v;
      bit          ok;
      send({3'b101, 3'd1, 10'h155}, ok);
      total_cnt++;
      if (!ok || bus.illegal_instr !== 1'b1 || bus.res_valid !== 1'b0 || bus.instr_ready !== 1'b1)
         $display("FAIL illegal_pulse ok=%0d illegal=%b valid=%b ready=%b required 1/1/0/1",
                  ok, bus.illegal_instr, bus.res_valid, bus.instr_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (bus.illegal_instr !== 1'b0 || bus.res_valid !== 1'b0)
         $display("FAIL illegal_one_shot illegal=%b valid=%b required 0/0", bus.illegal_instr, bus.res_valid);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), v);
         total_cnt++;
         if (v !== model[i]) $display("FAIL illegal_reg r%0d got %h required %h", i, v, model[i]);
         else pass_cnt++;
      end
`ifdef ALU_ISSUE_FLAGS_EN
      total_cnt++;
      if (flag_z !== exp_z || flag_n !== exp_n)
         $display("FAIL illegal_flags z=%b n=%b required %b/%b", flag_z, flag_n, exp_z, exp_n);
      else pass_cnt++;
`endif
   endtask

   task automatic test_random;
      logic [15:0] ins, v;
      logic [31:0] er;
      int          kind, lat, stall;
      bit          ok;
      for (int n = 0; n < 60; n++) begin
         ins   = 16'($urandom);
         stall = $urandom_range(0, 3);
         model_step(ins, er, kind);
         bus.res_ready = (stall == 0);
         send(ins, ok);
         total_cnt++;
         if (!ok) $display("FAIL rnd%0d_accept instr=%h not accepted within bound", n, ins);
         else pass_cnt++;
         if (kind == 2) begin
            total_cnt++;
            if (bus.illegal_instr !== 1'b1 || bus.res_valid !== 1'b0)
               $display("FAIL rnd%0d_illegal illegal=%b valid=%b required 1/0", n, bus.illegal_instr, bus.res_valid);
            else pass_cnt++;
         end else begin
            wait_result(lat);
            total_cnt++;
            if (lat != ((kind == 1) ? 1 : 2) || bus.res_data !== er || bus.res_rd !== ins[12:10])
               $display("FAIL rnd%0d_result instr=%h lat=%0d data=%h rd=%0d required lat=%0d data=%h rd=%0d",
                        n, ins, lat, bus.res_data, bus.res_rd, (kind == 1) ? 1 : 2, er, ins[12:10]);
            else pass_cnt++;
`ifdef ALU_ISSUE_FLAGS_EN
            total_cnt++;
            if (flag_z !== exp_z || flag_n !== exp_n)
               $display("FAIL rnd%0d_flags z=%b n=%b required %b/%b", n, flag_z, flag_n, exp_z, exp_n);
            else pass_cnt++;
`endif
            if (stall > 0) begin
               repeat (stall) @(negedge clk);
               total_cnt++;
               if (bus.res_valid !== 1'b1 || bus.res_data !== er)
                  $display("FAIL rnd%0d_stall valid=%b data=%h required 1/%h", n, bus.res_valid, bus.res_data, er);
               else pass_cnt++;
               bus.res_ready = 1'b1;
            end
            @(posedge clk); #1;
         end
      end
      bus.res_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), v);
         total_cnt++;
         if (v !== model[i]) $display("FAIL rnd_final_reg r%0d got %h required %h", i, v, model[i]);
         else pass_cnt++;
      end
   endtask

   task automatic test_reset_mid_exec;
      logic [15:0] v;
      bit          ok, seen;
      send({3'b000, 3'd7, 3'd1, 3'd2, 4'd0}, ok);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (!ok || bus.instr_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== 32'd0 ||
          bus.res_rd !== 3'd0 || bus.alu_a !== 16'd0 || bus.alu_b !== 16'd0 || bus.alu_opcode !== 3'd0)
         $display("FAIL midreset_outputs ready=%b valid=%b data=%h rd=%0d a=%h b=%h opc=%0d required 1/0/0/0/0/0/0",
                  bus.instr_ready, bus.res_valid, bus.res_data, bus.res_rd, bus.alu_a, bus.alu_b, bus.alu_opcode);
      else pass_cnt++;
      for (int i = 0; i < 8; i++) model[i] = 16'h0000;
      exp_z = 1'b0;
      exp_n = 1'b0;
      for (int i = 0; i < 8; i++) begin
         peek(3'(i), v);
         total_cnt++;
         if (v !== 16'h0000) $display("FAIL midreset_reg r%0d got %h required 0000", i, v);
         else pass_cnt++;
      end
`ifdef ALU_ISSUE_FLAGS_EN
      total_cnt++;
      if (flag_z !== 1'b0 || flag_n !== 1'b0)
         $display("FAIL midreset_flags z=%b n=%b required 0/0", flag_z, flag_n);
      else pass_cnt++;
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (bus.res_valid !== 1'b0) seen = 1'b1;
      end
      total_cnt++;
      if (seen) $display("FAIL midreset_dropped res_valid=1 after reset, required dropped instruction");
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_ldi_add();
      test_sub();
      test_backpressure();
      test_illegal();
      test_random();
      test_reset_mid_exec();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog simulation did not complete within time bound");
      $fatal(1);
   end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Decode/operand-fetch/writeback sequencer that sits directly upstream of the 3-bit-opcode, 16-bit-operand, 32-bit-result ALU.
- Accepts 16-bit instructions from the external instruction port with a valid/ready handshake and reads operands from an internal register file.
- Drives the ALU's a/b/opcode inputs and captures its 32-bit result.
- Writes the low 16 bits back to the register file and presents the full result downstream.

Parameters:
- NREGS, 8, number of 16-bit architectural registers (power of 2, index width = $clog2(NREGS), fixed 3 in encoding)
- RESET_VAL, 16'h0000, reset value of every register file entry

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid  input  1  instruction presented
- instr  input  16  [15:13] op, [12:10] rd, [9:7] rs1, [6:4] rs2; LDI uses [9:0] imm
- instr_ready  output  1  stage can accept instruction
- alu_a  output  16  operand A to ALU
- alu_b  output  16  operand B to ALU
- alu_opcode  output  3  opcode to ALU
- alu_out  input  32  ALU combinational result
- res_valid  output  1  result held for downstream
- res_ready  input  1  downstream accepts result
- res_data  output  32  captured result
- res_rd  output  3  destination register of result
- illegal_instr  output  1  one-cycle pulse on op 3'b101/3'b110
- dbg_addr  input  3  register file debug read address
- dbg_data  output  16  combinational read of regfile[dbg_addr]

Behaviour:
- Reset: state=IDLE; all regfile entries=RESET_VAL; instr_ready=1; res_valid=0; res_data=0; res_rd=0; alu_a=alu_b=0; alu_opcode=0; illegal_instr=0.
- FSM states: IDLE, EXEC, HOLD.
- IDLE:
  - instr_ready=1.
  - On instr_valid, latch instr into instr_q.
  - Ops 000-100 -> EXEC.
  - Op 111 (LDI) -> HOLD, with res_data = zero-extended imm10, res_rd = rd, and rd written with imm at the same edge.
  - Ops 101/110 -> pulse illegal_instr next cycle, stay IDLE, no write.
- EXEC:
  - instr_ready=0.
  - alu_a=regfile[rs1], alu_b=regfile[rs2], alu_opcode=op_q; these are registered from instr_q, so they are stable for the entire EXEC cycle.
  - At the end of EXEC: res_data<=alu_out, res_rd<=rd_q, regfile[rd_q]<=alu_out[15:0]; -> HOLD.
- HOLD:
  - res_valid=1; res_data and res_rd are stable until the handshake completes.
  - On res_valid&&res_ready -> IDLE; the next instruction can be accepted the following cycle.
- Latency: ALU op accept-to-res_valid = 2 cycles. LDI = 1 cycle. Throughput is at most 1 instruction per 3 cycles (ALU) or per 2 cycles (LDI).
- Hazards: none possible, because the writeback edge precedes the next operand read. rs1==rd and rs2==rd read the old value.
- alu_out bits [31:16] are passed through on res_data and discarded for the register file. The 32'hDEADBEEF default result is never produced because illegal ops never reach EXEC.
- dbg_data reflects a write on the cycle after the write edge.
- Reset asserted mid-operation: immediate return to reset values; any in-flight instruction is dropped.

Optional Feature:
- Macro: ALU_ISSUE_FLAGS_EN.
- When defined:
  - Adds outputs flag_z (1) and flag_n (1), registered at the same edge as each writeback.
  - flag_z = (written 16-bit value == 0); flag_n = bit 15 of the written value.
  - Both reset to 0; they are unchanged on illegal ops.
- When undefined: the ports and logic are absent.

Decomposition:
- Package alu_issue_pkg:
  - enum state_t {IDLE, EXEC, HOLD}
  - opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_LDI=111
  - field slice localparams
  - function is_illegal(op)
- Sub-module alu_issue_regfile:
  - NREGS x 16
  - two combinational read ports plus the debug read port
  - one synchronous write port
  - async active-low reset to RESET_VAL

Test Plan:
- Reset check -> all regs read 0 via dbg, instr_ready=1, res_valid=0.
- LDI r1,#0x3FF; LDI r2,#5; ADD r3,r1,r2 with res_ready=1 -> res_data=32'h0000_0404, res_rd=3, res_valid two cycles after ADD accept; dbg r3=0x0404.
- SUB r4,r2,r1 (5-0x3FF) -> res_data=ALU 32-bit result (0xFFFF_FC06); r4=0xFC06; flag_n=1 when ALU_ISSUE_FLAGS_EN is defined.
- Backpressure: res_ready=0 for 5 cycles after XOR r5,r1,r1 -> res_valid held, res_data=0 stable, instr_ready=0; release -> accept the next instruction on the following cycle; flag_z=1 when the flags feature is defined.
- Op 3'b101 -> illegal_instr one pulse, no register changed, no res_valid, instr_ready stays 1.
- rst_n asserted during EXEC -> all outputs and registers return to reset values asynchronously; the in-flight result is never presented.
